// File: rtl/updn_ctrl_pkg.sv
// updn_ctrl_pkg: shared state, mode and direction encodings for the counter sequencer. Rev 1.0
`default_nettype none

package updn_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_UP_WRAP   = 2'b00;
  localparam logic [1:0] MODE_DOWN_STOP = 2'b01;
  localparam logic [1:0] MODE_PINGPONG  = 2'b10;
  localparam logic [1:0] MODE_ONESHOT   = 2'b11;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

`default_nettype wire

// File: rtl/updn_tick_gen.sv
// updn_tick_gen: prescaler counting 0..PRESCALE-1 while enabled, tick on the last value. Rev 1.0
`default_nettype none

module updn_tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/updn_counter_ctrl.sv
// updn_counter_ctrl: START/STOP/MODE sequencer for the up/down counter. Rev 1.0
// Build macro UPDN_CTRL_DEBOUNCE_EN adds a DB_CYCLES-sample button debouncer.
`default_nettype none

module updn_counter_ctrl
  import updn_ctrl_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int PRESCALE  = 4,
  parameter int DB_CYCLES = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             STOP,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] HI,
  input  logic [WIDTH-1:0] CNT_Q,
  output logic             CNT_EN,
  output logic             CNT_M,
  output logic             CNT_CLR,
  output logic             BUSY,
  output logic             DONE
);

  // Button conditioning: bit 0 = START, bit 1 = STOP.
  logic [1:0] btn_raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] btn_lvl;
  logic [1:0] btn_prev;
  logic       start_p;
  logic       stop_p;

  assign btn_raw = {STOP, START};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

`ifdef UPDN_CTRL_DEBOUNCE_EN
  localparam int DBW = $clog2(DB_CYCLES + 1);

  for (genvar i = 0; i < 2; i++) begin : g_db
    logic [DBW-1:0] db_cnt;
    logic           db_lvl;

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        db_cnt <= '0;
        db_lvl <= 1'b0;
      end else if (sync2[i] == db_lvl) begin
        db_cnt <= '0;
      end else if (db_cnt == DBW'(DB_CYCLES - 1)) begin
        db_lvl <= sync2[i];
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end

    assign btn_lvl[i] = db_lvl;
  end
`else
  assign btn_lvl = sync2;

  if (DB_CYCLES < 1) begin : g_db_range
  end
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) btn_prev <= 2'b00;
    else      btn_prev <= btn_lvl;
  end

  assign start_p = btn_lvl[0] && !btn_prev[0];
  assign stop_p  = btn_lvl[1] && !btn_prev[1];

  // Sequencer state and step logic.
  state_t     state;
  state_t     state_nxt;
  logic [1:0] mode_q;
  logic [1:0] mode_nxt;
  logic       dir;
  logic       dir_nxt;
  logic       en_nxt;
  logic       clr_nxt;
  logic       launch;
  logic       pre_en;
  logic       tick;
  logic       at_top;
  logic       at_zero;
  logic       hi_zero;

  assign launch  = (state == ST_IDLE || state == ST_DONE) && start_p && !stop_p;
  // A STOP arriving on a tick cycle freezes the prescaler so resume steps at once.
  assign pre_en  = (state == ST_RUN) && !stop_p;
  assign at_top  = (CNT_Q >= HI);
  assign at_zero = (CNT_Q == '0);
  assign hi_zero = (HI == '0);

  updn_tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk   (CLK),
    .rst_n (RST),
    .en    (pre_en),
    .clr   (launch),
    .tick  (tick)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode_q;
    dir_nxt   = dir;
    en_nxt    = 1'b0;
    clr_nxt   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (launch) begin
          state_nxt = ST_RUN;
          mode_nxt  = MODE;
          if (MODE == MODE_DOWN_STOP) begin
            dir_nxt = DIR_DN;
          end else begin
            dir_nxt = DIR_UP;
            clr_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (stop_p) begin
          state_nxt = ST_PAUSE;
        end else if (tick) begin
          case (mode_q)
            MODE_UP_WRAP: begin
              if (at_top) clr_nxt = 1'b1;
              else begin en_nxt = 1'b1; dir_nxt = DIR_UP; end
            end
            MODE_DOWN_STOP: begin
              if (at_zero) state_nxt = ST_DONE;
              else begin en_nxt = 1'b1; dir_nxt = DIR_DN; end
            end
            MODE_PINGPONG: begin
              // With HI=0 the direction still toggles but no step leaves zero.
              if (dir == DIR_UP) begin
                if (at_top) begin dir_nxt = DIR_DN; en_nxt = !hi_zero; end
                else        en_nxt = 1'b1;
              end else begin
                if (at_zero) begin dir_nxt = DIR_UP; en_nxt = !hi_zero; end
                else         en_nxt = 1'b1;
              end
            end
            MODE_ONESHOT: begin
              if (at_top) state_nxt = ST_DONE;
              else begin en_nxt = 1'b1; dir_nxt = DIR_UP; end
            end
          endcase
        end
      end
      ST_PAUSE: begin
        if (start_p && !stop_p) state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mode_q  <= MODE_UP_WRAP;
      dir     <= DIR_UP;
      CNT_EN  <= 1'b0;
      CNT_CLR <= 1'b0;
    end else begin
      mode_q  <= mode_nxt;
      dir     <= dir_nxt;
      CNT_EN  <= en_nxt;
      CNT_CLR <= clr_nxt;
    end
  end

  assign CNT_M = dir;
  assign BUSY  = (state == ST_RUN) || (state == ST_PAUSE);
  assign DONE  = (state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_updn_counter_ctrl.sv
// tb_updn_counter_ctrl: directed bench with an attached 4-bit up/down counter model.
`default_nettype none
`timescale 1ns/1ps

module tb_updn_counter_ctrl;
  import updn_ctrl_pkg::*;

  localparam int WIDTH     = 4;
  localparam int PRESCALE  = 4;
  localparam int DB_CYCLES = 8;
`ifdef UPDN_CTRL_DEBOUNCE_EN
  localparam int LAT = DB_CYCLES + 3;
`else
  localparam int LAT = 3;
`endif

  logic             CLK   = 1'b0;
  logic             RST   = 1'b0;
  logic             START = 1'b0;
  logic             STOP  = 1'b0;
  logic [1:0]       MODE  = 2'b00;
  logic [WIDTH-1:0] HI    = 4'd9;
  logic [WIDTH-1:0] cnt_q = 4'd0;
  logic             CNT_EN, CNT_M, CNT_CLR, BUSY, DONE;
  logic             load     = 1'b0;
  logic [WIDTH-1:0] load_val = 4'd0;

  int total = 0;
  int bad   = 0;

  updn_counter_ctrl #(
    .WIDTH     (WIDTH),
    .PRESCALE  (PRESCALE),
    .DB_CYCLES (DB_CYCLES)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .STOP    (STOP),
    .MODE    (MODE),
    .HI      (HI),
    .CNT_Q   (cnt_q),
    .CNT_EN  (CNT_EN),
    .CNT_M   (CNT_M),
    .CNT_CLR (CNT_CLR),
    .BUSY    (BUSY),
    .DONE    (DONE)
  );

  always #5 CLK = ~CLK;

  // Counter model: synchronous clear has priority over the step strobe.
  always @(posedge CLK) begin
    if (load)         cnt_q <= load_val;
    else if (CNT_CLR) cnt_q <= 4'd0;
    else if (CNT_EN)  cnt_q <= CNT_M ? cnt_q - 4'd1 : cnt_q + 4'd1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic reset_dut();
    START = 1'b0; STOP = 1'b0;
    RST = 1'b0; cyc(2);
    RST = 1'b1; cyc(2);
  endtask

  task automatic load_cnt(input logic [WIDTH-1:0] v);
    load_val = v; load = 1'b1; cyc(1); load = 1'b0;
  endtask

  task automatic press(input logic s, input logic p);
    START = s; STOP = p; cyc(LAT);
    START = 1'b0; STOP = 1'b0;
  endtask

  task automatic wait_step(output logic en, output logic clr, output logic m, output int n);
    en = 1'b0; clr = 1'b0; m = 1'b0; n = 0;
    while (n < 40 && !en && !clr) begin
      @(negedge CLK); n++;
      if (CNT_EN || CNT_CLR) begin en = CNT_EN; clr = CNT_CLR; m = CNT_M; end
    end
  endtask

  task automatic wait_done(output int n, output logic seen);
    n = 0; seen = 1'b0;
    while (!DONE && n < 40) begin
      @(negedge CLK); n++;
      if (CNT_EN || CNT_CLR) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; cyc(2);
    total++;
    if ({CNT_EN, CNT_M, CNT_CLR, BUSY, DONE} !== 5'b0) begin
      bad++; $display("FAIL reset_outputs en,m,clr,busy,done=%b want 00000", {CNT_EN, CNT_M, CNT_CLR, BUSY, DONE});
    end
    RST = 1'b1; cyc(3);
    press(1'b0, 1'b1); cyc(4);
    total++;
    if (BUSY !== 1'b0 || CNT_CLR !== 1'b0 || CNT_EN !== 1'b0) begin
      bad++; $display("FAIL stop_in_idle busy=%b clr=%b en=%b want 0 0 0", BUSY, CNT_CLR, CNT_EN);
    end
  endtask

  task automatic test_up_wrap();
    logic en, clr, m; int n; logic [WIDTH-1:0] exp; logic exp_clr;
    reset_dut(); load_cnt(4'd7); MODE = MODE_UP_WRAP; HI = 4'd9;
    START = 1'b1; cyc(LAT - 1);
    total++;
    if (CNT_CLR !== 1'b0 || BUSY !== 1'b0) begin
      bad++; $display("FAIL start_latency_early clr=%b busy=%b want 0 0", CNT_CLR, BUSY);
    end
    cyc(1); START = 1'b0;
    total++;
    if (CNT_CLR !== 1'b1 || BUSY !== 1'b1 || CNT_EN !== 1'b0) begin
      bad++; $display("FAIL up_wrap_start clr=%b busy=%b en=%b want 1 1 0", CNT_CLR, BUSY, CNT_EN);
    end
    cyc(1);
    total++;
    if (cnt_q !== 4'd0) begin bad++; $display("FAIL up_wrap_cleared q=%0d want 0", cnt_q); end
    exp = 4'd0;
    for (int k = 0; k < 14; k++) begin
      wait_step(en, clr, m, n);
      exp_clr = (exp >= 4'd9);
      exp = exp_clr ? 4'd0 : exp + 4'd1;
      total++;
      if (n !== 3 || en !== !exp_clr || clr !== exp_clr || (en && m !== 1'b0)) begin
        bad++; $display("FAIL up_wrap_step%0d gap=%0d en=%b clr=%b m=%b want gap=3 en=%b clr=%b m=0", k, n, en, clr, m, !exp_clr, exp_clr);
      end
      cyc(1);
      total++;
      if (cnt_q !== exp) begin bad++; $display("FAIL up_wrap_value%0d q=%0d want %0d", k, cnt_q, exp); end
    end
  endtask

  task automatic test_pingpong();
    logic en, clr, m; int n; logic [WIDTH-1:0] exp; logic d, exp_m;
    reset_dut(); load_cnt(4'd3); MODE = MODE_PINGPONG; HI = 4'd9;
    press(1'b1, 1'b0);
    total++;
    if (CNT_CLR !== 1'b1) begin bad++; $display("FAIL pingpong_start clr=%b want 1", CNT_CLR); end
    cyc(1);
    exp = 4'd0; d = DIR_UP;
    for (int k = 0; k < 22; k++) begin
      wait_step(en, clr, m, n);
      if (d == DIR_UP && exp >= 4'd9) d = DIR_DN;
      else if (d == DIR_DN && exp == 4'd0) d = DIR_UP;
      exp_m = d;
      exp = (d == DIR_DN) ? exp - 4'd1 : exp + 4'd1;
      total++;
      if (en !== 1'b1 || clr !== 1'b0 || m !== exp_m) begin
        bad++; $display("FAIL pingpong_step%0d en=%b clr=%b m=%b want 1 0 %b", k, en, clr, m, exp_m);
      end
      cyc(1);
      total++;
      if (cnt_q !== exp || cnt_q > 4'd9) begin bad++; $display("FAIL pingpong_value%0d q=%0d want %0d", k, cnt_q, exp); end
    end
  endtask

  task automatic test_oneshot();
    logic en, clr, m, seen; int n;
    reset_dut(); MODE = MODE_ONESHOT; HI = 4'd9;
    press(1'b1, 1'b0);
    cyc(1);
    for (int k = 1; k <= 9; k++) begin
      wait_step(en, clr, m, n); cyc(1);
      total++;
      if (en !== 1'b1 || m !== 1'b0 || cnt_q !== 4'(k)) begin
        bad++; $display("FAIL oneshot_step%0d en=%b m=%b q=%0d want 1 0 %0d", k, en, m, cnt_q, k);
      end
    end
    wait_done(n, seen);
    total++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || seen !== 1'b0 || n !== 3) begin
      bad++; $display("FAIL oneshot_done done=%b busy=%b pulse=%b wait=%0d want 1 0 0 3", DONE, BUSY, seen, n);
    end
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin @(negedge CLK); if (CNT_EN || CNT_CLR) seen = 1'b1; end
    total++;
    if (seen !== 1'b0 || cnt_q !== 4'd9 || DONE !== 1'b1) begin
      bad++; $display("FAIL oneshot_hold pulse=%b q=%0d done=%b want 0 9 1", seen, cnt_q, DONE);
    end
    press(1'b1, 1'b0);
    total++;
    if (CNT_CLR !== 1'b1 || BUSY !== 1'b1 || DONE !== 1'b0) begin
      bad++; $display("FAIL oneshot_restart clr=%b busy=%b done=%b want 1 1 0", CNT_CLR, BUSY, DONE);
    end
    cyc(1); wait_step(en, clr, m, n); cyc(1);
    total++;
    if (en !== 1'b1 || cnt_q !== 4'd1) begin bad++; $display("FAIL oneshot_rerun en=%b q=%0d want 1 1", en, cnt_q); end
  endtask

  task automatic test_down_stop();
    logic en, clr, m, seen; int n;
    reset_dut(); load_cnt(4'd5); MODE = MODE_DOWN_STOP; HI = 4'd9;
    press(1'b1, 1'b0);
    total++;
    if (CNT_CLR !== 1'b0 || BUSY !== 1'b1) begin
      bad++; $display("FAIL down_start clr=%b busy=%b want 0 1", CNT_CLR, BUSY);
    end
    for (int k = 4; k >= 0; k--) begin
      wait_step(en, clr, m, n); cyc(1);
      total++;
      if (en !== 1'b1 || clr !== 1'b0 || m !== 1'b1 || cnt_q !== 4'(k)) begin
        bad++; $display("FAIL down_step%0d en=%b clr=%b m=%b q=%0d want 1 0 1 %0d", k, en, clr, m, cnt_q, k);
      end
    end
    wait_done(n, seen);
    total++;
    if (DONE !== 1'b1 || BUSY !== 1'b0 || seen !== 1'b0 || n !== 3 || cnt_q !== 4'd0) begin
      bad++; $display("FAIL down_done done=%b busy=%b pulse=%b wait=%0d q=%0d want 1 0 0 3 0", DONE, BUSY, seen, n, cnt_q);
    end
    press(1'b1, 1'b0);
    total++;
    if (BUSY !== 1'b1 || DONE !== 1'b0 || CNT_CLR !== 1'b0) begin
      bad++; $display("FAIL down_zero_start busy=%b done=%b clr=%b want 1 0 0", BUSY, DONE, CNT_CLR);
    end
    wait_done(n, seen);
    total++;
    if (DONE !== 1'b1 || seen !== 1'b0 || n !== 4) begin
      bad++; $display("FAIL down_zero_done done=%b pulse=%b wait=%0d want 1 0 4", DONE, seen, n);
    end
  endtask

  task automatic test_pause_resume();
    logic en, clr, m, seen; int n;
    reset_dut(); MODE = MODE_UP_WRAP; HI = 4'd9;
    press(1'b1, 1'b0); cyc(1);
    repeat (4) begin wait_step(en, clr, m, n); cyc(1); end
    total++;
    if (cnt_q !== 4'd4) begin bad++; $display("FAIL pause_setup q=%0d want 4", cnt_q); end
    press(1'b0, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin @(negedge CLK); if (CNT_EN || CNT_CLR) seen = 1'b1; end
    total++;
    if (BUSY !== 1'b1 || DONE !== 1'b0 || seen !== 1'b0 || cnt_q !== 4'd4) begin
      bad++; $display("FAIL pause_hold busy=%b done=%b pulse=%b q=%0d want 1 0 0 4", BUSY, DONE, seen, cnt_q);
    end
    press(1'b1, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin @(negedge CLK); if (CNT_EN || CNT_CLR) seen = 1'b1; end
    total++;
    if (BUSY !== 1'b1 || seen !== 1'b0 || cnt_q !== 4'd4) begin
      bad++; $display("FAIL start_stop_together busy=%b pulse=%b q=%0d want 1 0 4", BUSY, seen, cnt_q);
    end
    press(1'b1, 1'b0);
    wait_step(en, clr, m, n); cyc(1);
    total++;
    if (en !== 1'b1 || clr !== 1'b0 || m !== 1'b0 || cnt_q !== 4'd5) begin
      bad++; $display("FAIL resume en=%b clr=%b m=%b q=%0d want 1 0 0 5", en, clr, m, cnt_q);
    end
  endtask

  task automatic test_reset_and_hi0();
    logic en, clr, m; int n;
    reset_dut(); MODE = MODE_UP_WRAP; HI = 4'd9;
    press(1'b1, 1'b0); cyc(1);
    wait_step(en, clr, m, n); cyc(1);
    wait_step(en, clr, m, n);
    RST = 1'b0; #1;
    total++;
    if ({CNT_EN, CNT_M, CNT_CLR, BUSY, DONE} !== 5'b0) begin
      bad++; $display("FAIL async_reset en,m,clr,busy,done=%b want 00000", {CNT_EN, CNT_M, CNT_CLR, BUSY, DONE});
    end
    cyc(3);
    total++;
    if (cnt_q !== 4'd1) begin bad++; $display("FAIL reset_keeps_count q=%0d want 1", cnt_q); end
    RST = 1'b1; cyc(2);
    HI = 4'd0;
    press(1'b1, 1'b0);
    total++;
    if (CNT_CLR !== 1'b1) begin bad++; $display("FAIL hi0_start clr=%b want 1", CNT_CLR); end
    cyc(1);
    for (int k = 0; k < 4; k++) begin
      wait_step(en, clr, m, n); cyc(1);
      total++;
      if (clr !== 1'b1 || en !== 1'b0 || n !== 3 || cnt_q !== 4'd0) begin
        bad++; $display("FAIL hi0_tick%0d clr=%b en=%b gap=%0d q=%0d want 1 0 3 0", k, clr, en, n, cnt_q);
      end
    end
    HI = 4'd9;
  endtask

`ifdef UPDN_CTRL_DEBOUNCE_EN
  task automatic test_debounce_glitch();
    logic seen;
    reset_dut(); MODE = MODE_UP_WRAP;
    seen = 1'b0;
    START = 1'b1;
    for (int k = 0; k < 5; k++) begin @(negedge CLK); if (CNT_CLR || BUSY) seen = 1'b1; end
    START = 1'b0;
    for (int k = 0; k < 20; k++) begin @(negedge CLK); if (CNT_CLR || BUSY) seen = 1'b1; end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL debounce_glitch reacted=%b want 0", seen); end
  endtask
`endif

  initial begin
    test_reset();
    test_up_wrap();
    test_pingpong();
    test_oneshot();
    test_down_stop();
    test_pause_resume();
    test_reset_and_hi0();
`ifdef UPDN_CTRL_DEBOUNCE_EN
    test_debounce_glitch();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
